// File: rtl/p405s_dcu_dataoutseq.sv
// Byte-lane select sequencer for the DCU data-out bypass mux: arbitrates fill bypass,
// hit loads (one or two beats) and dcread tag reads onto four registered 2-bit selects.
module p405s_dcu_dataoutseq #(
  parameter int unsigned TAG_RD_LAT = 2
) (
  input  logic       cb,
  input  logic       core_reset,
  input  logic       fill_byp,
  input  logic [3:0] fill_byp_byte_en,
  input  logic       ld_req,
  input  logic [1:0] ld_src1,
  input  logic [3:0] ld_byte_en1,
  input  logic       ld_span,
  input  logic [1:0] ld_src2,
  input  logic [3:0] ld_byte_en2,
  input  logic       tag_rd_req,
  output logic       ld_ack,
  output logic       tag_rd_ack,
  output logic [1:0] dout_mux_sel_byte0,
  output logic [1:0] dout_mux_sel_byte1,
  output logic [1:0] dout_mux_sel_byte2,
  output logic [1:0] dout_mux_sel_byte3,
  output logic [3:0] data_byte_val,
  output logic       data_last,
  output logic       seq_busy
);

  // state    | meaning
  // IDLE     | no transfer in flight; loads and tag reads may be accepted
  // BEAT2    | beat 1 of a spanning load sent; beat 2 goes out next free cycle
  // TAG_WAIT | tag read accepted; counting down until tag data reaches the mux
  typedef enum logic [1:0] {IDLE, BEAT2, TAG_WAIT} state_t;

  // The counter holds the wait cycles left before the tag beat is registered,
  // so a value of 0 means the tag beat goes out on this edge.
  localparam logic [2:0] TAG_LOAD = (TAG_RD_LAT > 1) ? 3'(TAG_RD_LAT - 2) : 3'd0;

  state_t          state;
  logic [3:0][1:0] sel;
  logic [1:0]      src2_q;
  logic [3:0]      en2_q;
  logic [2:0]      tag_cnt;

  // Byte-enable bit 3 is lane 0 (big-endian lane numbering).
  function automatic logic [3:0][1:0] steer(input logic [3:0][1:0] cur,
                                            input logic [3:0] en,
                                            input logic [1:0] src);
    logic [3:0][1:0] r;
    r = cur;
    for (int lane = 0; lane < 4; lane++)
      if (en[3-lane]) r[lane] = src;
    return r;
  endfunction

  function automatic logic [1:0] norm_src(input logic [1:0] s);
    return (s == 2'b10) ? 2'b10 : 2'b00;
  endfunction

  assign ld_ack     = !core_reset && !fill_byp && (state == IDLE) && ld_req;
  assign tag_rd_ack = !core_reset && !fill_byp && (state == IDLE) && !ld_req && tag_rd_req;
  assign seq_busy   = (state != IDLE);

  assign dout_mux_sel_byte0 = sel[0];
  assign dout_mux_sel_byte1 = sel[1];
  assign dout_mux_sel_byte2 = sel[2];
  assign dout_mux_sel_byte3 = sel[3];

  always_ff @(posedge cb) begin
    if (core_reset) begin
      state         <= IDLE;
      sel           <= '0;
      data_byte_val <= '0;
      data_last     <= 1'b0;
      src2_q        <= '0;
      en2_q         <= '0;
      tag_cnt       <= '0;
    end else begin
      data_byte_val <= '0;
      data_last     <= 1'b0;
      if (fill_byp) begin
        // Fill preempts everything; whatever was in flight simply holds.
        sel           <= steer(sel, fill_byp_byte_en, 2'b01);
        data_byte_val <= fill_byp_byte_en;
        data_last     <= 1'b1;
      end else begin
        case (state)
          BEAT2: begin
            sel           <= steer(sel, en2_q, src2_q);
            data_byte_val <= en2_q;
            data_last     <= 1'b1;
            state         <= IDLE;
          end
          TAG_WAIT: begin
            if (tag_cnt == 3'd0) begin
              sel           <= {4{2'b11}};
              data_byte_val <= 4'hF;
              data_last     <= 1'b1;
              state         <= IDLE;
            end else begin
              tag_cnt <= tag_cnt - 3'd1;
            end
          end
          default: begin
            if (ld_req) begin
              sel           <= steer(sel, ld_byte_en1, norm_src(ld_src1));
              data_byte_val <= ld_byte_en1;
              data_last     <= !ld_span;
              if (ld_span) begin
                src2_q <= norm_src(ld_src2);
                en2_q  <= ld_byte_en2;
                state  <= BEAT2;
              end
            end else if (tag_rd_req) begin
              if (TAG_RD_LAT == 1) begin
                sel           <= {4{2'b11}};
                data_byte_val <= 4'hF;
                data_last     <= 1'b1;
              end else begin
                tag_cnt <= TAG_LOAD;
                state   <= TAG_WAIT;
              end
            end
          end
        endcase
      end
    end
  end

  a_ld_lanes_disjoint: assert property (@(posedge cb) disable iff (core_reset)
    (ld_ack && ld_span) |-> ((ld_byte_en1 & ld_byte_en2) == 4'b0000));

endmodule

// File: tb/tb_p405s_dcu_dataoutseq.sv
// Random and directed stimulus for the data-out sequencer, checked against a
// queue-based model of pending beats and a tag-read countdown.
module tb_p405s_dcu_dataoutseq;
  localparam int LAT = 2;

  logic       clk = 1'b0;
  logic       core_reset, fill_byp, ld_req, ld_span, tag_rd_req;
  logic [3:0] fill_byp_byte_en, ld_byte_en1, ld_byte_en2;
  logic [1:0] ld_src1, ld_src2;
  logic       ld_ack, tag_rd_ack, data_last, seq_busy;
  logic [1:0] sel0, sel1, sel2, sel3;
  logic [3:0] data_byte_val;

  int n_vec = 0;
  int n_err = 0;

  typedef struct { logic [3:0] en; logic [1:0] src; } beat_t;
  beat_t      beat_q[$];
  int         tag_left = 0;
  logic [1:0] exp_sel [4];
  logic [3:0] exp_val;
  logic       exp_last;

  p405s_dcu_dataoutseq #(.TAG_RD_LAT(LAT)) dut (
    .cb(clk), .core_reset(core_reset), .fill_byp(fill_byp), .fill_byp_byte_en(fill_byp_byte_en),
    .ld_req(ld_req), .ld_src1(ld_src1), .ld_byte_en1(ld_byte_en1), .ld_span(ld_span),
    .ld_src2(ld_src2), .ld_byte_en2(ld_byte_en2), .tag_rd_req(tag_rd_req),
    .ld_ack(ld_ack), .tag_rd_ack(tag_rd_ack),
    .dout_mux_sel_byte0(sel0), .dout_mux_sel_byte1(sel1),
    .dout_mux_sel_byte2(sel2), .dout_mux_sel_byte3(sel3),
    .data_byte_val(data_byte_val), .data_last(data_last), .seq_busy(seq_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [1:0] legal_src(input logic [1:0] s);
    return (s == 2'b10) ? 2'b10 : 2'b00;
  endfunction

  // Lane 0 is byte-enable bit 3.
  task automatic emit(input logic [3:0] en, input logic [1:0] src, input logic last);
    for (int l = 0; l < 4; l++) if (en[3-l]) exp_sel[l] = src;
    exp_val  = en;
    exp_last = last;
  endtask

  task automatic step(input logic rst, input logic fb, input logic [3:0] fbe,
                      input logic lr, input logic [1:0] s1, input logic [3:0] e1,
                      input logic sp, input logic [1:0] s2, input logic [3:0] e2,
                      input logic tr);
    logic busy, exp_la, exp_ta;
    @(negedge clk);
    core_reset = rst; fill_byp = fb; fill_byp_byte_en = fbe;
    ld_req = lr; ld_src1 = s1; ld_byte_en1 = e1; ld_span = sp;
    ld_src2 = s2; ld_byte_en2 = e2; tag_rd_req = tr;
    busy   = (beat_q.size() != 0) || (tag_left != 0);
    exp_la = !rst && !fb && !busy && lr;
    exp_ta = !rst && !fb && !busy && !lr && tr;
    #1;
    chk("ld_ack", 32'(ld_ack), 32'(exp_la));
    chk("tag_rd_ack", 32'(tag_rd_ack), 32'(exp_ta));
    exp_val = 4'h0; exp_last = 1'b0;
    if (rst) begin
      beat_q.delete(); tag_left = 0;
      for (int l = 0; l < 4; l++) exp_sel[l] = 2'b00;
    end else if (fb) begin
      emit(fbe, 2'b01, 1'b1);
    end else if (beat_q.size() != 0) begin
      beat_t b;
      b = beat_q.pop_front();
      emit(b.en, b.src, 1'b1);
    end else if (tag_left != 0) begin
      if (tag_left == 1) begin emit(4'hF, 2'b11, 1'b1); tag_left = 0; end
      else tag_left--;
    end else if (lr) begin
      emit(e1, legal_src(s1), !sp);
      if (sp) beat_q.push_back('{en: e2, src: legal_src(s2)});
    end else if (tr) begin
      if (LAT == 1) emit(4'hF, 2'b11, 1'b1);
      else tag_left = LAT - 1;
    end
    @(posedge clk); #1;
    chk("sel0", 32'(sel0), 32'(exp_sel[0]));
    chk("sel1", 32'(sel1), 32'(exp_sel[1]));
    chk("sel2", 32'(sel2), 32'(exp_sel[2]));
    chk("sel3", 32'(sel3), 32'(exp_sel[3]));
    chk("data_byte_val", 32'(data_byte_val), 32'(exp_val));
    chk("data_last", 32'(data_last), 32'(exp_last));
    chk("seq_busy", 32'(seq_busy), 32'((beat_q.size() != 0) || (tag_left != 0)));
  endtask

  task automatic idle();
    step(0, 0, 4'h0, 0, 2'b00, 4'h0, 0, 2'b00, 4'h0, 0);
  endtask

  initial begin
    for (int l = 0; l < 4; l++) exp_sel[l] = 2'b00;
    repeat (2) step(1, 0, 4'h0, 0, 2'b00, 4'h0, 0, 2'b00, 4'h0, 0);
    idle();

    // Full-word load from way A, then literal check of the result.
    step(0, 0, 4'h0, 1, 2'b10, 4'hF, 0, 2'b00, 4'h0, 0);
    chk("t2_sel0_lit", 32'(sel0), 32'h2);
    chk("t2_val_lit", 32'(data_byte_val), 32'hF);

    // Two-beat load: lanes 2,3 from way B then lanes 0,1 from way A.
    step(0, 0, 4'h0, 1, 2'b00, 4'h3, 1, 2'b10, 4'hC, 0);
    chk("t3_sel0_hold_lit", 32'(sel0), 32'h2);
    chk("t3_sel3_lit", 32'(sel3), 32'h0);
    idle();
    chk("t3_beat2_sel1_lit", 32'(sel1), 32'h2);

    // Fill bypass preempting beat 2.
    step(0, 0, 4'h0, 1, 2'b11, 4'h9, 1, 2'b10, 4'h6, 0);
    step(0, 1, 4'hF, 0, 2'b00, 4'h0, 0, 2'b00, 4'h0, 0);
    chk("t4_fill_sel2_lit", 32'(sel2), 32'h1);
    idle();

    // Tag read with a load arriving while waiting.
    step(0, 0, 4'h0, 0, 2'b00, 4'h0, 0, 2'b00, 4'h0, 1);
    step(0, 0, 4'h0, 1, 2'b10, 4'hF, 0, 2'b00, 4'h0, 0);
    chk("t5_tag_sel0_lit", 32'(sel0), 32'h3);
    idle();

    // Load wins over tag in the same cycle; tag accepted next.
    step(0, 0, 4'h0, 1, 2'b10, 4'h1, 0, 2'b00, 4'h0, 1);
    step(0, 0, 4'h0, 0, 2'b00, 4'h0, 0, 2'b00, 4'h0, 1);
    repeat (2) idle();

    // Zero-lane load and reset held mid-BEAT2.
    step(0, 0, 4'h0, 1, 2'b10, 4'h0, 0, 2'b00, 4'h0, 0);
    step(0, 0, 4'h0, 1, 2'b10, 4'hA, 1, 2'b00, 4'h5, 0);
    repeat (3) step(1, 0, 4'h0, 0, 2'b00, 4'h0, 0, 2'b00, 4'h0, 0);
    chk("t1_busy_lit", 32'(seq_busy), 32'h0);
    idle();

    for (int i = 0; i < 3000; i++) begin
      logic [3:0] e1, e2;
      e1 = 4'($urandom);
      e2 = 4'($urandom) & ~e1;
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 4) == 0), 4'($urandom),
           ($urandom_range(0, 2) == 0), 2'($urandom), e1, 1'($urandom), 2'($urandom), e2,
           ($urandom_range(0, 3) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
